regfile_port_arbiter: RTL and testbench

//   Shares the register file's single access port set (rs/rt read, rd write) between the multicycle

---
 rtl/regfile_port_arbiter_pkg.sv | 23 ++
 rtl/arb_starve_cnt.sv | 44 ++++
 rtl/regfile_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : regfile_port_arbiter_pkg
// Brief  : Shared FSM encodings, default widths and register-zero constant.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_port_arbiter_pkg;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_CORE = 2'd1,
    ST_GRANT_DBG  = 2'd2,
    ST_RESP       = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
//------------------------------------------------------------------------------
// Module : arb_starve_cnt
// Brief  : Saturating count of core grants issued while debug is waiting.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CW'(STARVE_MAX));

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : regfile_port_arbiter
// Brief  : Shares the register file port set between core FSM and debug port
//          as 3-cycle transactions. Debug port enabled by REGFILE_ARB_DBG_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_rs,
  input  logic [AW-1:0] core_rt,
  input  logic [AW-1:0] core_rd,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_done,
  output logic [DW-1:0] core_rdata_a,
  output logic [DW-1:0] core_rdata_b,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] rf_rs,
  output logic [AW-1:0] rf_rt,
  output logic [AW-1:0] rf_rd,
  output logic          rf_we,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_data_a,
  input  logic [DW-1:0] rf_data_b
);

  arb_state_e    state_q, state_d;
  logic          lat_we_q, lat_we_d;
  logic          lat_dbg_q, lat_dbg_d;
  logic [AW-1:0] lat_rs_q, lat_rs_d;
  logic [AW-1:0] lat_rt_q, lat_rt_d;
  logic [AW-1:0] lat_rd_q, lat_rd_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic [DW-1:0] core_rdata_a_q, core_rdata_a_d;
  logic [DW-1:0] core_rdata_b_q, core_rdata_b_d;
  logic          core_win;
  logic          dbg_win;
  logic          in_grant;

`ifdef REGFILE_ARB_DBG_EN
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          starve_at_max;
  logic          starve_inc;
  logic          starve_clr;

  // Core normally wins; debug takes one slot once core has starved it long enough.
  assign dbg_win    = dbg_req && (!core_req || starve_at_max);
  assign core_win   = core_req && !dbg_win;
  assign starve_inc = (state_q == ST_IDLE) && core_win && dbg_req;
  assign starve_clr = !dbg_req || ((state_q == ST_IDLE) && dbg_win);

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );
`else
  logic unused_dbg;

  assign dbg_win    = 1'b0;
  assign core_win   = core_req;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata} ^ (STARVE_MAX == 0);
`endif

  always_comb begin
    state_d        = state_q;
    lat_we_d       = lat_we_q;
    lat_dbg_d      = lat_dbg_q;
    lat_rs_d       = lat_rs_q;
    lat_rt_d       = lat_rt_q;
    lat_rd_d       = lat_rd_q;
    lat_wdata_d    = lat_wdata_q;
    core_rdata_a_d = core_rdata_a_q;
    core_rdata_b_d = core_rdata_b_q;
`ifdef REGFILE_ARB_DBG_EN
    dbg_rdata_d    = dbg_rdata_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (core_win) begin
          state_d     = ST_GRANT_CORE;
          lat_dbg_d   = 1'b0;
          lat_we_d    = core_we;
          lat_rs_d    = core_rs;
          lat_rt_d    = core_rt;
          lat_rd_d    = core_rd;
          lat_wdata_d = core_wdata;
        end
`ifdef REGFILE_ARB_DBG_EN
        else if (dbg_win) begin
          state_d     = ST_GRANT_DBG;
          lat_dbg_d   = 1'b1;
          lat_we_d    = dbg_we;
          lat_rs_d    = dbg_addr;
          lat_rt_d    = '0;
          lat_rd_d    = dbg_addr;
          lat_wdata_d = dbg_wdata;
        end
`endif
      end
      ST_GRANT_CORE: begin
        state_d = ST_RESP;
        if (!lat_we_q) begin
          core_rdata_a_d = rf_data_a;
          core_rdata_b_d = rf_data_b;
        end
      end
      ST_GRANT_DBG: begin
        state_d = ST_RESP;
`ifdef REGFILE_ARB_DBG_EN
        if (!lat_we_q) begin
          dbg_rdata_d = rf_data_a;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      lat_we_q       <= 1'b0;
      lat_dbg_q      <= 1'b0;
      lat_rs_q       <= '0;
      lat_rt_q       <= '0;
      lat_rd_q       <= '0;
      lat_wdata_q    <= '0;
      core_rdata_a_q <= '0;
      core_rdata_b_q <= '0;
    end else begin
      state_q        <= state_d;
      lat_we_q       <= lat_we_d;
      lat_dbg_q      <= lat_dbg_d;
      lat_rs_q       <= lat_rs_d;
      lat_rt_q       <= lat_rt_d;
      lat_rd_q       <= lat_rd_d;
      lat_wdata_q    <= lat_wdata_d;
      core_rdata_a_q <= core_rdata_a_d;
      core_rdata_b_q <= core_rdata_b_d;
    end
  end

`ifdef REGFILE_ARB_DBG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_gnt   = (state_q == ST_GRANT_DBG);
  assign dbg_done  = (state_q == ST_RESP) && lat_dbg_q;
  assign dbg_rdata = dbg_rdata_q;
`else
  assign dbg_gnt   = 1'b0;
  assign dbg_done  = 1'b0;
  assign dbg_rdata = '0;
`endif

  // Port drive is purely state-decoded so an async reset releases the file at once.
  assign in_grant     = (state_q == ST_GRANT_CORE) || (state_q == ST_GRANT_DBG);
  assign rf_rs        = in_grant ? lat_rs_q : '0;
  assign rf_rt        = in_grant ? lat_rt_q : '0;
  assign rf_rd        = in_grant ? lat_rd_q : '0;
  assign rf_wdata     = in_grant ? lat_wdata_q : '0;
  assign rf_we        = in_grant && lat_we_q && (lat_rd_q != AW'(REG_ZERO));
  assign core_gnt     = (state_q == ST_GRANT_CORE);
  assign core_done    = (state_q == ST_RESP) && !lat_dbg_q;
  assign core_rdata_a = core_rdata_a_q;
  assign core_rdata_b = core_rdata_b_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_regfile_port_arbiter
// Brief  : Directed bench for regfile_port_arbiter with a behavioural register file.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_init = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [4:0]  core_rs = '0, core_rt = '0, core_rd = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_done;
  logic [31:0] core_rdata_a, core_rdata_b;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_rs, rf_rt, rf_rd;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_data_a, rf_data_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];

  regfile_port_arbiter #(.AW(5), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_rs(core_rs), .core_rt(core_rt),
    .core_rd(core_rd), .core_wdata(core_wdata), .core_gnt(core_gnt), .core_done(core_done),
    .core_rdata_a(core_rdata_a), .core_rdata_b(core_rdata_b),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
  );

  always #5 clk = ~clk;

  assign rf_data_a = rf_mem[rf_rs];
  assign rf_data_b = rf_mem[rf_rt];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : (32'hAAAA0000 | i);
    end else if (rf_we) begin
      rf_mem[rf_rd] <= rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rs, rt, rd;
    logic [31:0] wdata;
    logic        exp_we;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [7];

  task automatic core_txn(input logic we, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] wdata, input logic exp_we,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_rs = rs; core_rt = rt; core_rd = rd; core_wdata = wdata;
    @(posedge clk); #1;
    chk("grant_gnt", {31'b0, core_gnt}, 32'd1);
    chk("grant_done", {31'b0, core_done}, 32'd0);
    chk("grant_rf_we", {31'b0, rf_we}, {31'b0, exp_we});
    if (we) begin
      chk("grant_rf_rd", {27'b0, rf_rd}, {27'b0, rd});
      chk("grant_rf_wdata", rf_wdata, wdata);
    end else begin
      chk("grant_rf_rs", {27'b0, rf_rs}, {27'b0, rs});
      chk("grant_rf_rt", {27'b0, rf_rt}, {27'b0, rt});
    end
    @(posedge clk); #1;
    chk("resp_done", {31'b0, core_done}, 32'd1);
    chk("resp_gnt_rfwe", {30'b0, core_gnt, rf_we}, 32'd0);
    chk("resp_rf_addr", {17'b0, rf_rs, rf_rt, rf_rd}, 32'd0);
    chk("rdata_a", core_rdata_a, exp_a);
    chk("rdata_b", core_rdata_b, exp_b);
    @(negedge clk);
    core_req = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", {30'b0, core_done, core_gnt}, 32'd0);
    chk("rdata_a_held", core_rdata_a, exp_a);
  endtask

`ifdef REGFILE_ARB_DBG_EN
  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    @(posedge clk); #1;
    chk("dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg_rf_addr", {22'b0, rf_rs, rf_rd}, {22'b0, addr, addr});
    chk("dbg_rf_we", {31'b0, rf_we}, {31'b0, we && (addr != 5'd0)});
    @(posedge clk); #1;
    chk("dbg_done", {30'b0, dbg_done, core_done}, 32'd2);
    chk("dbg_rdata", dbg_rdata, exp_rdata);
    @(negedge clk);
    dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    vecs[0] = '{1'b0, 5'd3,  5'd5,  5'd0,  32'h0,        1'b0, 32'hAAAA0003, 32'hAAAA0005};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd7,  32'h12345678, 1'b1, 32'hAAAA0003, 32'hAAAA0005};
    vecs[2] = '{1'b0, 5'd7,  5'd0,  5'd0,  32'h0,        1'b0, 32'h12345678, 32'h00000000};
    vecs[3] = '{1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b0, 32'h12345678, 32'h00000000};
    vecs[4] = '{1'b0, 5'd0,  5'd31, 5'd0,  32'h0,        1'b0, 32'h00000000, 32'hAAAA001F};
    vecs[5] = '{1'b1, 5'd0,  5'd0,  5'd31, 32'hDEADBEEF, 1'b1, 32'h00000000, 32'hAAAA001F};
    vecs[6] = '{1'b0, 5'd31, 5'd3,  5'd0,  32'h0,        1'b0, 32'hDEADBEEF, 32'hAAAA0003};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'b0, core_gnt, core_done, dbg_gnt, dbg_done, rf_we}, 32'd0);
    chk("rst_rf", {17'b0, rf_rs, rf_rt, rf_rd} | rf_wdata, 32'd0);
    chk("rst_rdata", core_rdata_a | core_rdata_b | dbg_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; tb_init = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_req", {30'b0, core_gnt, dbg_gnt}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      core_txn(vecs[i].we, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wdata,
               vecs[i].exp_we, vecs[i].exp_a, vecs[i].exp_b);
    end

    // Async reset in the grant cycle of a write
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_rd = 5'd12; core_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("abort_pre_gnt_we", {30'b0, core_gnt, rf_we}, 32'd3);
    #2;
    rst = 1'b1; core_req = 1'b0;
    #1;
    chk("abort_gnt_we_low", {30'b0, core_gnt, rf_we}, 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (core_done || core_gnt || rf_we) seen++;
        if (c == 1) begin
          @(negedge clk);
          rst = 1'b0;
        end
      end
      chk("abort_no_done", seen, 0);
    end
    core_txn(1'b0, 5'd12, 5'd7, 5'd0, 32'h0, 1'b0, 32'hAAAA000C, 32'h12345678);

`ifdef REGFILE_ARB_DBG_EN
    begin
      logic exp_seq [10];
      logic got_seq [10];
      int   n = 0;
      for (int k = 0; k < 10; k++) begin
        exp_seq[k] = (k == 4) || (k == 9);
        got_seq[k] = 1'b0;
      end
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_rs = 5'd3; core_rt = 5'd5;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
      for (int c = 0; c < 60 && n < 10; c++) begin
        @(posedge clk); #1;
        if (core_gnt && dbg_gnt) chk("dual_grant", 32'd1, 32'd0);
        if (core_gnt || dbg_gnt) begin
          got_seq[n] = dbg_gnt;
          n++;
        end
      end
      chk("starve_grant_count", n, 10);
      for (int k = 0; k < 10; k++) chk($sformatf("starve_seq[%0d]", k), {31'b0, got_seq[k]}, {31'b0, exp_seq[k]});
      @(negedge clk);
      core_req = 1'b0; dbg_req = 1'b0;
      @(posedge clk); #1;
      chk("starve_dbg_done", {31'b0, dbg_done}, 32'd1);
      chk("starve_dbg_rdata", dbg_rdata, 32'hAAAA0005);
      @(posedge clk); #1;
    end
    dbg_txn(1'b1, 5'd9, 32'hCAFEF00D, 32'hAAAA0005);
    dbg_txn(1'b0, 5'd9, 32'h0, 32'hCAFEF00D);
    dbg_txn(1'b1, 5'd0, 32'h55555555, 32'hCAFEF00D);
    core_txn(1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 32'hCAFEF00D, 32'h00000000);
`else
    begin
      int seen = 0;
      @(negedge clk);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h11111111;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (dbg_gnt || dbg_done || (dbg_rdata != 32'h0) || core_gnt || rf_we) seen++;
      end
      chk("dbg_disabled_quiet", seen, 0);
    end
    core_txn(1'b0, 5'd4, 5'd31, 5'd0, 32'h0, 1'b0, 32'hAAAA0004, 32'hDEADBEEF);
    core_txn(1'b1, 5'd0, 5'd0, 5'd4, 32'h44444444, 1'b1, 32'hAAAA0004, 32'hDEADBEEF);
    core_txn(1'b0, 5'd4, 5'd0, 5'd0, 32'h0, 1'b0, 32'h44444444, 32'h00000000);
    chk("dbg_disabled_rdata", dbg_rdata, 32'h0);
    dbg_req = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
